// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external data-memory port between the CPU
// load/store unit and the GEMM accelerator mover. It uses round-robin
// arbitration and allows one outstanding transaction at a time. Request
// fields are registered on grant, and every transaction has a watchdog
// timeout.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   cpu_* / acc_*         requester side: cs/rd_wr/mask/addr/wdata in,
//                         rdata/valid/err out (valid is a 1-cycle pulse)
//   mem_*                 memory side: cs/rd_wr/mask/addr/write_data out,
//                         read_data/valid in
//   busy                  high whenever the arbiter is not idle
module mem_port_arbiter #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       TIMEOUT  = 64,
    parameter logic [DATA_W-1:0] ERR_DATA = '0
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                cpu_cs,
    input  logic                cpu_rd_wr,
    input  logic [DATA_W/8-1:0] cpu_mask,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_valid,
    output logic                cpu_err,

    input  logic                acc_cs,
    input  logic                acc_rd_wr,
    input  logic [DATA_W/8-1:0] acc_mask,
    input  logic [ADDR_W-1:0]   acc_addr,
    input  logic [DATA_W-1:0]   acc_wdata,
    output logic [DATA_W-1:0]   acc_rdata,
    output logic                acc_valid,
    output logic                acc_err,

    output logic                mem_cs,
    output logic                mem_rd_wr,
    output logic [DATA_W/8-1:0] mem_mask,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_write_data,
    input  logic [DATA_W-1:0]   mem_read_data,
    input  logic                mem_valid,

    output logic                busy
);

    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned CNT_W  = 16;
    localparam logic        GRANT_ACC = 1'b1;

    typedef enum logic [1:0] {IDLE, XFER_CPU, XFER_ACC, RESP} state_t;

    state_t              state, state_n;
    logic                last_grant, last_grant_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                mem_cs_n, mem_rd_wr_n;
    logic [MASK_W-1:0]   mem_mask_n;
    logic [ADDR_W-1:0]   mem_addr_n;
    logic [DATA_W-1:0]   mem_write_data_n;
    logic [DATA_W-1:0]   cpu_rdata_n, acc_rdata_n;
    logic                cpu_valid_n, acc_valid_n, cpu_err_n, acc_err_n;
    logic                busy_n;
    logic                grant_acc;
    logic                xfer_done;
    logic [DATA_W-1:0]   resp_data;

    // Next-state and registered-output logic
    always_comb begin
        state_n          = state;
        last_grant_n     = last_grant;
        cnt_n            = cnt;
        mem_cs_n         = mem_cs;
        mem_rd_wr_n      = mem_rd_wr;
        mem_mask_n       = mem_mask;
        mem_addr_n       = mem_addr;
        mem_write_data_n = mem_write_data;
        cpu_rdata_n      = cpu_rdata;
        acc_rdata_n      = acc_rdata;
        cpu_valid_n      = 1'b0;
        acc_valid_n      = 1'b0;
        cpu_err_n        = 1'b0;
        acc_err_n        = 1'b0;
        grant_acc        = 1'b0;
        // mem_valid wins over the watchdog in the final cycle
        xfer_done        = mem_valid || (cnt == CNT_W'(TIMEOUT - 1));
        resp_data        = mem_valid ? mem_read_data : ERR_DATA;

        case (state)
            IDLE: begin
                if (cpu_cs || acc_cs) begin
                    // On a tie the master not served last time wins
                    grant_acc        = acc_cs && (!cpu_cs || (last_grant != GRANT_ACC));
                    state_n          = grant_acc ? XFER_ACC : XFER_CPU;
                    last_grant_n     = grant_acc;
                    cnt_n            = '0;
                    mem_cs_n         = 1'b1;
                    mem_rd_wr_n      = grant_acc ? acc_rd_wr : cpu_rd_wr;
                    mem_mask_n       = grant_acc ? acc_mask  : cpu_mask;
                    mem_addr_n       = grant_acc ? acc_addr  : cpu_addr;
                    mem_write_data_n = mem_rd_wr_n ? '0 :
                                       (grant_acc ? acc_wdata : cpu_wdata);
                end
            end
            XFER_CPU, XFER_ACC: begin
                if (xfer_done) begin
                    mem_cs_n = 1'b0;
                    state_n  = RESP;
                    if (state == XFER_ACC) begin
                        acc_valid_n = 1'b1;
                        acc_err_n   = !mem_valid;
                        if (mem_rd_wr) acc_rdata_n = resp_data;
                    end else begin
                        cpu_valid_n = 1'b1;
                        cpu_err_n   = !mem_valid;
                        if (mem_rd_wr) cpu_rdata_n = resp_data;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            last_grant     <= GRANT_ACC;
            cnt            <= '0;
            mem_cs         <= 1'b0;
            mem_rd_wr      <= 1'b0;
            mem_mask       <= '0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            cpu_rdata      <= '0;
            acc_rdata      <= '0;
            cpu_valid      <= 1'b0;
            acc_valid      <= 1'b0;
            cpu_err        <= 1'b0;
            acc_err        <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_n;
            last_grant     <= last_grant_n;
            cnt            <= cnt_n;
            mem_cs         <= mem_cs_n;
            mem_rd_wr      <= mem_rd_wr_n;
            mem_mask       <= mem_mask_n;
            mem_addr       <= mem_addr_n;
            mem_write_data <= mem_write_data_n;
            cpu_rdata      <= cpu_rdata_n;
            acc_rdata      <= acc_rdata_n;
            cpu_valid      <= cpu_valid_n;
            acc_valid      <= acc_valid_n;
            cpu_err        <= cpu_err_n;
            acc_err        <= acc_err_n;
            busy           <= busy_n;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios with literal
// expectations plus randomized traffic, all checked against a timeline
// model of transactions kept inside the bench.
module tb_mem_port_arbiter;

    localparam int unsigned TO = 4;
    localparam logic [31:0] ERRD = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_cs = 1'b0, cpu_rd_wr = 1'b0;
    logic [3:0]  cpu_mask = 4'h0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_valid, cpu_err;
    logic        acc_cs = 1'b0, acc_rd_wr = 1'b0;
    logic [3:0]  acc_mask = 4'h0;
    logic [31:0] acc_addr = '0, acc_wdata = '0;
    logic [31:0] acc_rdata;
    logic        acc_valid, acc_err;
    logic        mem_cs, mem_rd_wr;
    logic [3:0]  mem_mask;
    logic [31:0] mem_addr, mem_write_data;
    logic [31:0] mem_read_data = '0;
    logic        mem_valid = 1'b0;
    logic        busy;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
        .clk(clk), .reset(reset),
        .cpu_cs(cpu_cs), .cpu_rd_wr(cpu_rd_wr), .cpu_mask(cpu_mask), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_valid(cpu_valid), .cpu_err(cpu_err),
        .acc_cs(acc_cs), .acc_rd_wr(acc_rd_wr), .acc_mask(acc_mask), .acc_addr(acc_addr),
        .acc_wdata(acc_wdata), .acc_rdata(acc_rdata), .acc_valid(acc_valid), .acc_err(acc_err),
        .mem_cs(mem_cs), .mem_rd_wr(mem_rd_wr), .mem_mask(mem_mask), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .mem_valid(mem_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    // A transaction granted by the edge closing cycle c occupies the memory
    // from cycle c+1 until it completes in cycle e (memory response, or
    // the TIMEOUT-th cycle). The requester sees its pulse in cycle e+1,
    // and the next request can be sampled at the end of cycle e+2.
    int          cyc = 0;
    bit          active = 0;
    bit          tx_acc = 0, tx_rd = 0;
    logic [3:0]  tx_mask = '0;
    logic [31:0] tx_addr = '0, tx_wdata = '0;
    int          tx_start = 0, arb_cyc = 0, age;
    bit          last_acc = 1;
    logic [31:0] m_rd_cpu = '0, m_rd_acc = '0;
    bit          fields_chk = 1;
    bit          e_cs = 0, e_busy = 0, e_cv = 0, e_av = 0, e_ce = 0, e_ae = 0;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            active = 0; last_acc = 1; arb_cyc = 0;
            m_rd_cpu = '0; m_rd_acc = '0;
            tx_rd = 0; tx_mask = '0; tx_addr = '0; tx_wdata = '0; fields_chk = 1;
            e_cs = 0; e_busy = 0; e_cv = 0; e_av = 0; e_ce = 0; e_ae = 0;
        end
        chk("mem_cs", 64'(mem_cs), 64'(e_cs));
        chk("busy", 64'(busy), 64'(e_busy));
        chk("cpu_valid", 64'(cpu_valid), 64'(e_cv));
        chk("acc_valid", 64'(acc_valid), 64'(e_av));
        chk("cpu_err", 64'(cpu_err), 64'(e_ce));
        chk("acc_err", 64'(acc_err), 64'(e_ae));
        chk("cpu_rdata", 64'(cpu_rdata), 64'(m_rd_cpu));
        chk("acc_rdata", 64'(acc_rdata), 64'(m_rd_acc));
        if (fields_chk) begin
            chk("mem_rd_wr", 64'(mem_rd_wr), 64'(tx_rd));
            chk("mem_mask", 64'(mem_mask), 64'(tx_mask));
            chk("mem_addr", 64'(mem_addr), 64'(tx_addr));
            chk("mem_write_data", 64'(mem_write_data), 64'(tx_rd ? 32'h0 : tx_wdata));
        end
        if (!reset) begin
            e_cv = 0; e_av = 0; e_ce = 0; e_ae = 0;
            if (active) begin
                age = cyc - tx_start + 1;
                if (mem_valid || age >= int'(TO)) begin
                    active = 0; fields_chk = 0; arb_cyc = cyc + 2;
                    if (tx_acc) begin
                        e_av = 1; e_ae = !mem_valid;
                        if (tx_rd) m_rd_acc = mem_valid ? mem_read_data : ERRD;
                    end else begin
                        e_cv = 1; e_ce = !mem_valid;
                        if (tx_rd) m_rd_cpu = mem_valid ? mem_read_data : ERRD;
                    end
                end
            end else if (cyc >= arb_cyc && (cpu_cs || acc_cs)) begin
                tx_acc   = cpu_cs ? (acc_cs && !last_acc) : 1'b1;
                last_acc = tx_acc;
                tx_rd    = tx_acc ? acc_rd_wr : cpu_rd_wr;
                tx_mask  = tx_acc ? acc_mask  : cpu_mask;
                tx_addr  = tx_acc ? acc_addr  : cpu_addr;
                tx_wdata = tx_acc ? acc_wdata : cpu_wdata;
                tx_start = cyc + 1; active = 1; fields_chk = 1;
            end
            e_cs   = active;
            e_busy = active || e_cv || e_av;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int  order[$];
    int  rises[$];
    bit  prev_cs, seen, got_err;
    int  n_cs;
    logic [31:0] got_rd;

    initial begin
        repeat (3) tick();
        chk("reset_mem_cs", 64'(mem_cs), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_cpu_rdata", 64'(cpu_rdata), 64'(0));
        reset = 1'b0;
        tick();

        // CPU read, response in the second mem_cs cycle
        cpu_cs = 1; cpu_rd_wr = 1; cpu_addr = 32'h100; cpu_mask = 4'hF; cpu_wdata = 32'h5555_AAAA;
        tick();
        chk("t1_mem_cs_c1", 64'(mem_cs), 64'(1));
        chk("t1_addr", 64'(mem_addr), 64'h100);
        chk("t1_rd_wr", 64'(mem_rd_wr), 64'(1));
        chk("t1_wdata_zero", 64'(mem_write_data), 64'(0));
        tick();
        chk("t1_mem_cs_c2", 64'(mem_cs), 64'(1));
        mem_valid = 1; mem_read_data = 32'hCAFE_F00D;
        tick();
        mem_valid = 0;
        chk("t1_cpu_valid", 64'(cpu_valid), 64'(1));
        chk("t1_cpu_rdata", 64'(cpu_rdata), 64'hCAFE_F00D);
        chk("t1_cpu_err", 64'(cpu_err), 64'(0));
        chk("t1_acc_valid", 64'(acc_valid), 64'(0));
        chk("t1_mem_cs_off", 64'(mem_cs), 64'(0));
        tick();
        cpu_cs = 0;
        chk("t1_pulse_once", 64'(cpu_valid), 64'(0));
        tick();

        // ACC write, 1-cycle response
        acc_cs = 1; acc_rd_wr = 0; acc_addr = 32'h200; acc_mask = 4'b0011; acc_wdata = 32'h1234_5678;
        tick();
        chk("t2_wdata", 64'(mem_write_data), 64'h1234_5678);
        chk("t2_mask", 64'(mem_mask), 64'h3);
        chk("t2_rd_wr", 64'(mem_rd_wr), 64'(0));
        chk("t2_addr", 64'(mem_addr), 64'h200);
        mem_valid = 1;
        tick();
        mem_valid = 0;
        chk("t2_acc_valid", 64'(acc_valid), 64'(1));
        chk("t2_acc_err", 64'(acc_err), 64'(0));
        chk("t2_acc_rdata_kept", 64'(acc_rdata), 64'(0));
        tick();
        acc_cs = 0;
        tick();

        // Fairness from reset, memory answers in 1 cycle
        reset = 1; tick(); reset = 0;
        cpu_cs = 1; cpu_rd_wr = 1; acc_cs = 1; acc_rd_wr = 1;
        mem_read_data = 32'hA5A5_0001;
        prev_cs = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (mem_cs && !prev_cs) rises.push_back(k);
            prev_cs = mem_cs;
            if (cpu_valid) order.push_back(0);
            if (acc_valid) order.push_back(1);
            mem_valid = mem_cs;
        end
        cpu_cs = 0; acc_cs = 0; mem_valid = 0;
        chk("t3_grant_count", 64'(order.size() >= 4), 64'(1));
        for (int i = 0; i < 4; i++)
            if (i < order.size()) chk("t3_grant_order", 64'(order[i]), 64'(i % 2));
        chk("t3_rise_count", 64'(rises.size() >= 4), 64'(1));
        for (int i = 1; i < 4; i++)
            if (i < rises.size()) chk("t3_cadence", 64'(rises[i] - rises[i-1]), 64'(3));
        repeat (4) tick();

        // CPU read timeout
        cpu_cs = 1; cpu_rd_wr = 1; cpu_addr = 32'h300;
        n_cs = 0; seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (mem_cs) n_cs++;
            if (cpu_valid) begin seen = 1; got_err = cpu_err; got_rd = cpu_rdata; cpu_cs = 0; end
        end
        chk("t4_cs_cycles", 64'(n_cs), 64'(4));
        chk("t4_seen", 64'(seen), 64'(1));
        chk("t4_err", 64'(got_err), 64'(1));
        chk("t4_rdata", 64'(got_rd), 64'(0));

        // Response in the final cycle counts as success
        cpu_cs = 1; n_cs = 0; seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (mem_cs) begin
                n_cs++;
                mem_valid = (n_cs == 4);
                mem_read_data = 32'h0BAD_CAFE;
            end else mem_valid = 0;
            if (cpu_valid) begin seen = 1; got_err = cpu_err; got_rd = cpu_rdata; cpu_cs = 0; end
        end
        mem_valid = 0;
        chk("t4b_cs_cycles", 64'(n_cs), 64'(4));
        chk("t4b_seen", 64'(seen), 64'(1));
        chk("t4b_err", 64'(got_err), 64'(0));
        chk("t4b_rdata", 64'(got_rd), 64'h0BAD_CAFE);

        // Stray mem_valid while idle
        for (int k = 0; k < 4; k++) begin
            mem_valid = 1;
            tick();
            chk("t5_busy", 64'(busy), 64'(0));
            chk("t5_valids", 64'({cpu_valid, acc_valid}), 64'(0));
        end
        mem_valid = 0;
        tick();

        // Reset in the middle of an ACC transfer
        acc_cs = 1; acc_rd_wr = 1; acc_addr = 32'h500;
        tick();
        chk("t6_busy", 64'(busy), 64'(1));
        tick();
        reset = 1;
        #1;
        chk("t6_async_cs", 64'(mem_cs), 64'(0));
        chk("t6_async_busy", 64'(busy), 64'(0));
        cpu_cs = 1; cpu_rd_wr = 1; cpu_addr = 32'h400;
        tick();
        chk("t6_no_acc_valid", 64'(acc_valid), 64'(0));
        tick();
        reset = 0;
        tick();
        chk("t6_regrant_cs", 64'(mem_cs), 64'(1));
        chk("t6_cpu_first", 64'(mem_addr), 64'h400);
        mem_valid = 1;
        tick();
        mem_valid = 0; cpu_cs = 0; acc_cs = 0;
        chk("t6_cpu_valid", 64'(cpu_valid), 64'(1));
        chk("t6_acc_quiet", 64'(acc_valid), 64'(0));
        repeat (3) tick();

        // Randomized traffic against the model
        for (int k = 0; k < 2500; k++) begin
            tick();
            reset         = ($urandom_range(0, 299) == 0);
            cpu_cs        = ($urandom_range(0, 3) != 0);
            acc_cs        = ($urandom_range(0, 3) != 0);
            cpu_rd_wr     = 1'($urandom_range(0, 1));
            acc_rd_wr     = 1'($urandom_range(0, 1));
            cpu_mask      = 4'($urandom_range(0, 15));
            acc_mask      = 4'($urandom_range(0, 15));
            cpu_addr      = $urandom;
            acc_addr      = $urandom;
            cpu_wdata     = $urandom;
            acc_wdata     = $urandom;
            mem_valid     = ($urandom_range(0, 2) == 0);
            mem_read_data = $urandom;
        end
        reset = 0; cpu_cs = 0; acc_cs = 0; mem_valid = 0;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master arbiter that shares the single external data-memory port (`mem_cs`, `mem_rd_wr`, `mem_mask`, `mem_addr`, `mem_write_data`, `mem_read_data`, `mem_valid`) between the RISC-V pipeline's load/store unit and the GEMM accelerator's operand/result mover. It is round-robin arbitrated and runs one outstanding transaction at a time. Request fields are registered on grant, and each transaction has a watchdog timeout. It sits between the core/accelerator top and the memory subsystem.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; mask width is `DATA_W/8`
- `TIMEOUT`, 64, max cycles `mem_cs` stays high waiting for `mem_valid`; legal range 2..65535
- `ERR_DATA`, 32'h0000_0000, read data returned on timeout

Ports. Reset is asynchronous, active-high; all flops are cleared on `reset` rising, independent of `clk`.
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `cpu_cs`  in  1  CPU request; held until `cpu_valid`
- `cpu_rd_wr`  in  1  1 = read, 0 = write
- `cpu_mask`  in  4  byte enables
- `cpu_addr`  in  ADDR_W  byte address
- `cpu_wdata`  in  DATA_W  store data
- `cpu_rdata`  out  DATA_W  load data, valid with `cpu_valid`
- `cpu_valid`  out  1  one-cycle completion pulse
- `cpu_err`  out  1  timeout flag, only with `cpu_valid`
- `acc_cs`, `acc_rd_wr`, `acc_mask`, `acc_addr`, `acc_wdata`, `acc_rdata`, `acc_valid`, `acc_err`: same as the `cpu_*` ports, for the accelerator
- `mem_cs`  out  1  memory select
- `mem_rd_wr`  out  1  1 = read, 0 = write
- `mem_mask`  out  4  byte enables
- `mem_addr`  out  ADDR_W  address
- `mem_write_data`  out  DATA_W  store data; 0 on reads
- `mem_read_data`  in  DATA_W  sampled when `mem_valid` = 1
- `mem_valid`  in  1  memory completion
- `busy`  out  1  state != IDLE

## Operation
- FSM states: IDLE, XFER_CPU, XFER_ACC, RESP.
- IDLE:
  - Exactly one `*_cs` high: grant that master.
  - Both high: grant the master that is not `last_grant`.
  - On grant: latch `rd_wr`, `mask`, `addr`, `wdata` into the `mem_*` registers, set `mem_cs`, set `last_grant`, clear the watchdog counter, go to XFER_x.
- XFER_x:
  - `mem_*` outputs are held constant. Requester inputs are ignored after grant.
  - `mem_valid` = 1: capture `mem_read_data` (reads only), clear `mem_cs`, go to RESP with err = 0.
  - Otherwise, when counter == TIMEOUT-1: clear `mem_cs`, go to RESP with err = 1 and rdata = `ERR_DATA` (reads only).
  - Otherwise: counter increments.
- RESP: pulse `x_valid` (and `x_err` if set) for the granted master for exactly one cycle, ignore all requests, go to IDLE.
- `x_rdata` is registered. It updates only on read completion or read timeout and otherwise holds its value. Write completions leave `x_rdata` unchanged.
- Requester rule: drop `cs` in the cycle after `x_valid`, or keep it high to present a new request. It is sampled in IDLE.
- `mem_valid` while in IDLE or RESP is ignored (stray); no state change.
- Reset values:
  - state IDLE, `last_grant` = ACC, so the CPU wins the first tie.
  - Counter 0; all `mem_*` outputs, `*_rdata`, `*_valid`, `*_err` and `busy` are 0.
- Reset mid-transaction: abort immediately, no valid pulse to either master; the memory side sees `mem_cs` fall asynchronously.

## Timing
- A request sampled in IDLE at edge E0 gives `mem_cs` = 1 in cycle 1, i.e. the cycle after E0.
- `mem_valid` sampled high in cycle k gives `x_valid` in cycle k+1 and IDLE in cycle k+2.
- Earliest next grant: sampled in IDLE at the end of cycle k+2, so the next `mem_cs` is in cycle k+3.
- Minimum transaction (`mem_valid` in cycle 1): `mem_cs` high 1 cycle, `x_valid` in cycle 2, back-to-back `mem_cs` cadence 3 cycles.
- Timeout: `mem_cs` is high for exactly TIMEOUT cycles, then `x_valid` + `x_err` in the next cycle.
- `mem_valid` in the final (TIMEOUT-th) cycle counts as success; err = 0.
- Fairness: with both masters continuously requesting, grants alternate strictly CPU, ACC, CPU, …
- Worst-case wait for a master is one other transaction plus RESP and IDLE: at most TIMEOUT+3 cycles.

## Test plan
- CPU read 0x0000_0100, memory returns 0xCAFE_F00D with `mem_valid` 2 cycles after `mem_cs` -> `mem_addr` = 0x100, `mem_rd_wr` = 1 stable for 2 cycles; `cpu_valid` pulses 1 cycle with `cpu_rdata` = 0xCAFE_F00D, `cpu_err` = 0; `acc_valid` stays 0.
- ACC write 0x1234_5678 to 0x200, mask 4'b0011 -> `mem_write_data` = 0x1234_5678, `mem_mask` = 3, `mem_rd_wr` = 0; `acc_valid` pulse; `acc_rdata` unchanged.
- Both `cs` high from reset, memory responds in 1 cycle -> grant order CPU, ACC, CPU, ACC; `mem_cs` rising edges exactly 3 cycles apart.
- CPU read, memory silent, TIMEOUT = 4 -> `mem_cs` high exactly 4 cycles; `cpu_valid` = `cpu_err` = 1 with `cpu_rdata` = 0. Repeat with `mem_valid` in cycle 4 -> success, err = 0.
- Stray `mem_valid` in IDLE -> no valid pulses, `busy` stays 0.
- Assert `reset` in the middle of the XFER_ACC transaction -> `mem_cs` drops asynchronously, no `acc_valid`. After release, a simultaneous CPU+ACC request grants CPU first.
